rr_event_arbiter_8: RTL and testbench

//  Captures rising-edge events on 8 asynchronous request lines and holds each one as a pending bit.

---
 rtl/rr_event_arbiter_8.sv | 130 +++++++++++++
 tb/tb_rr_event_arbiter_8.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/rr_event_arbiter_8.sv
// Rising-edge event capture on 8 async request lines with a round-robin, one-grant-at-a-time
// valid/ready output stage feeding a downstream 8-to-3 encoder.
module rr_event_arbiter_8 #(
  parameter int unsigned N           = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req_in,
  input  logic         en,
  output logic [N-1:0] grant_oh,
  output logic         grant_vld,
  input  logic         grant_rdy,
  output logic [N-1:0] pending,
  output logic         ovf
);

  if (N != 8) begin : g_bad_n
    $error("rr_event_arbiter_8: N must be 8");
  end
  if (SYNC_STAGES < 2 || SYNC_STAGES > 3) begin : g_bad_sync
    $error("rr_event_arbiter_8: SYNC_STAGES must be 2 or 3");
  end

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e       state_q, state_d;
  logic [N-1:0] sync_q [SYNC_STAGES];
  logic [N-1:0] prev_q;
  logic [N-1:0] pending_q, pending_d;
  logic [N-1:0] grant_oh_q, grant_oh_d;
  logic         grant_vld_q, grant_vld_d;
  logic [2:0]   gidx_q, gidx_d;
  logic [2:0]   ptr_q, ptr_d;
  logic         ovf_q, ovf_d;
  logic [N-1:0] edge_det;
  logic [N-1:0] clr;
  logic [2:0]   sel_idx;
  logic [2:0]   idx;
  logic         sel_found;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < int'(SYNC_STAGES); s++) sync_q[s] <= '0;
      prev_q <= '0;
    end else begin
      sync_q[0] <= req_in;
      for (int s = 1; s < int'(SYNC_STAGES); s++) sync_q[s] <= sync_q[s-1];
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign edge_det = sync_q[SYNC_STAGES-1] & ~prev_q;

  // Scan from the highest offset down so the lowest offset from ptr wins.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = ptr_q;
    idx       = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = ptr_q + 3'(k);
      if (pending_q[idx]) begin
        sel_found = 1'b1;
        sel_idx   = idx;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_oh_d  = grant_oh_q;
    grant_vld_d = grant_vld_q;
    gidx_d      = gidx_q;
    ptr_d       = ptr_q;
    clr         = '0;
    unique case (state_q)
      StIdle: begin
        if (en && sel_found) begin
          grant_oh_d  = N'(1) << sel_idx;
          grant_vld_d = 1'b1;
          gidx_d      = sel_idx;
          state_d     = StGrant;
        end else begin
          grant_oh_d  = '0;
          grant_vld_d = 1'b0;
        end
      end
      StGrant: begin
        if (grant_rdy) begin
          clr[gidx_q] = 1'b1;
          ptr_d       = gidx_q + 3'd1;
          grant_oh_d  = '0;
          grant_vld_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // An edge on the line being cleared this cycle is a fresh event, not a merge.
  assign pending_d = (pending_q & ~clr) | edge_det;
  assign ovf_d     = |(edge_det & pending_q & ~clr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      pending_q   <= '0;
      grant_oh_q  <= '0;
      grant_vld_q <= 1'b0;
      gidx_q      <= '0;
      ptr_q       <= '0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      grant_oh_q  <= grant_oh_d;
      grant_vld_q <= grant_vld_d;
      gidx_q      <= gidx_d;
      ptr_q       <= ptr_d;
      ovf_q       <= ovf_d;
    end
  end

  assign grant_oh  = grant_oh_q;
  assign grant_vld = grant_vld_q;
  assign pending   = pending_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_rr_event_arbiter_8.sv
// Directed self-checking bench for rr_event_arbiter_8; edge counts are relative to the
// first rising clock edge after a request line is driven.
module tb_rr_event_arbiter_8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req_in = '0;
  logic       en = 1'b0;
  logic [7:0] grant_oh;
  logic       grant_vld;
  logic       grant_rdy = 1'b0;
  logic [7:0] pending;
  logic       ovf;

  int tests = 0;
  int fails = 0;

  rr_event_arbiter_8 #(.N(8), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_in    (req_in),
    .en        (en),
    .grant_oh  (grant_oh),
    .grant_vld (grant_vld),
    .grant_rdy (grant_rdy),
    .pending   (pending),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  initial begin
    tick(2);
    check_eq("rst_grant_oh", grant_oh, 8'h00);
    check_eq("rst_vld", grant_vld, 1'b0);
    check_eq("rst_pending", pending, 8'h00);
    check_eq("rst_ovf", ovf, 1'b0);
    rst = 1'b0;
    en = 1'b1;
    grant_rdy = 1'b1;

    // 1: single event on line 5
    req_in = 8'h20;
    tick(2);
    check_eq("t1_pend_e2", pending, 8'h00);
    tick();
    check_eq("t1_pend_e3", pending, 8'h20);
    check_eq("t1_vld_e3", grant_vld, 1'b0);
    req_in = 8'h00;
    tick();
    check_eq("t1_grant_e4", grant_oh, 8'h20);
    check_eq("t1_vld_e4", grant_vld, 1'b1);
    tick();
    check_eq("t1_vld_e5", grant_vld, 1'b0);
    check_eq("t1_grant_e5", grant_oh, 8'h00);
    check_eq("t1_pend_e5", pending, 8'h00);

    // 2: lines 1,3,6 together from ptr=0
    do_reset();
    req_in = 8'h4A;
    tick(3);
    check_eq("t2_pend", pending, 8'h4A);
    req_in = 8'h00;
    tick();
    check_eq("t2_g1", grant_oh, 8'h02);
    check_eq("t2_g1_vld", grant_vld, 1'b1);
    tick();
    check_eq("t2_idle1", grant_vld, 1'b0);
    check_eq("t2_pend1", pending, 8'h48);
    tick();
    check_eq("t2_g2", grant_oh, 8'h08);
    tick();
    check_eq("t2_idle2", grant_vld, 1'b0);
    tick();
    check_eq("t2_g3", grant_oh, 8'h40);
    tick();
    check_eq("t2_idle3", grant_vld, 1'b0);
    check_eq("t2_pend3", pending, 8'h00);

    // 3: grant line 7, then lines 0 and 7 -> ptr wraps to 0
    req_in = 8'h80;
    tick(3);
    req_in = 8'h00;
    tick();
    check_eq("t3_g7", grant_oh, 8'h80);
    tick(4);
    req_in = 8'h81;
    tick(3);
    check_eq("t3_pend", pending, 8'h81);
    req_in = 8'h00;
    tick();
    check_eq("t3_first", grant_oh, 8'h01);
    tick();
    check_eq("t3_idle", grant_vld, 1'b0);
    tick();
    check_eq("t3_second", grant_oh, 8'h80);
    tick();
    check_eq("t3_pend_end", pending, 8'h00);

    // 4: held grant on line 2, en toggling, merged event
    tick(3);
    grant_rdy = 1'b0;
    req_in = 8'h04;
    tick(3);
    check_eq("t4_pend", pending, 8'h04);
    tick();
    check_eq("t4_grant", grant_oh, 8'h04);
    check_eq("t4_ovf_g", ovf, 1'b0);
    req_in = 8'h00;
    tick();
    check_eq("t4_hold1", grant_oh, 8'h04);
    en = 1'b0;
    tick();
    check_eq("t4_hold2", grant_oh, 8'h04);
    req_in = 8'h04;
    en = 1'b1;
    tick();
    check_eq("t4_hold3", grant_oh, 8'h04);
    en = 1'b0;
    tick();
    check_eq("t4_hold4", grant_oh, 8'h04);
    check_eq("t4_ovf4", ovf, 1'b0);
    en = 1'b1;
    tick();
    check_eq("t4_hold5", grant_oh, 8'h04);
    check_eq("t4_vld5", grant_vld, 1'b1);
    check_eq("t4_ovf5", ovf, 1'b1);
    check_eq("t4_pend5", pending, 8'h04);
    en = 1'b0;
    tick();
    check_eq("t4_ovf6", ovf, 1'b0);
    check_eq("t4_hold6", grant_oh, 8'h04);
    en = 1'b1;
    grant_rdy = 1'b1;
    req_in = 8'h00;
    tick();
    check_eq("t4_hs_vld", grant_vld, 1'b0);
    check_eq("t4_hs_pend", pending, 8'h00);

    // 5: en=0 captures but does not grant
    en = 1'b0;
    tick(2);
    req_in = 8'h10;
    tick(3);
    check_eq("t5_pend", pending, 8'h10);
    check_eq("t5_vld", grant_vld, 1'b0);
    req_in = 8'h00;
    tick(3);
    check_eq("t5_vld_hold", grant_vld, 1'b0);
    check_eq("t5_grant_hold", grant_oh, 8'h00);
    en = 1'b1;
    tick();
    check_eq("t5_grant", grant_oh, 8'h10);
    check_eq("t5_vld_on", grant_vld, 1'b1);
    tick();
    check_eq("t5_done", pending, 8'h00);

    // 6: async reset mid-grant; ptr=5 so line 1 is granted first
    grant_rdy = 1'b0;
    req_in = 8'h06;
    tick(3);
    check_eq("t6_pend", pending, 8'h06);
    tick();
    check_eq("t6_grant", grant_oh, 8'h02);
    req_in = 8'h00;
    #3 rst = 1'b1;
    #1;
    check_eq("t6_rst_vld", grant_vld, 1'b0);
    check_eq("t6_rst_grant", grant_oh, 8'h00);
    check_eq("t6_rst_pend", pending, 8'h00);
    @(posedge clk);
    #1 rst = 1'b0;
    tick(6);
    check_eq("t6_post_vld", grant_vld, 1'b0);
    check_eq("t6_post_pend", pending, 8'h00);
    check_eq("t6_post_ovf", ovf, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
